periph_bus_master: RTL and testbench
====================================

Name: periph_bus_master

Overview:
- Initiator for the on-chip peripheral register bus. Register blocks decode addr[31:16] against their base address.
- Accepts one command at a time from an upstream sequencer (valid/ready) and drives the bus with a single-cycle read or write strobe.
- For reads, waits for the registered read-data strobe, with a timeout; returns a response over a valid/ready channel.
- Sits between the UART/host command path and all peripheral register blocks on clk_125.

Parameters:
- TIMEOUT_CYC, 16: max cycles spent in WAIT_RD before declaring a read timeout; legal range 2..255.
- TIMEOUT_DATA, 32'hDEAD_BEEF: rsp_rdata value returned on a timed-out read.
- CNT_W, 8: width of the timeout error counter (optional feature).

Ports:
- clk_125  in  1  system clock
- rst_n_125  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  full bus address; [31:16] selects block, [15:0] selects register
- cmd_wdata  in  32  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  upstream accepts response
- rsp_write  out  1  echo of cmd_write for this response
- rsp_rdata  out  32  read data; 0 for writes
- rsp_err  out  1  1 = read timed out
- peripheral_addr_out  out  32  bus address
- peripheral_wdata_out  out  32  bus write data
- peripheral_read_en  out  1  read strobe
- peripheral_write_en  out  1  write strobe
- peripheral_rdata_in  in  32  read data from responders
- peripheral_rdata_in_en  in  1  read data valid strobe
- err_cnt  out  CNT_W  saturating timeout count (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk_125. All outputs registered. rst_n_125 is synchronous and active-low.
- Reset values: state IDLE; cmd_ready=1; rsp_valid=0; rsp_write=0; rsp_rdata=0; rsp_err=0; both strobes 0; peripheral_addr_out=0; peripheral_wdata_out=0; err_cnt=0.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at edge T: latch addr, wdata and write into the bus output registers; go to ISSUE.
- ISSUE (cycle T+1):
  - Exactly one of peripheral_write_en / peripheral_read_en is high, for one cycle only; cmd_ready=0.
  - Write: next state RESP with rsp_rdata=0, rsp_err=0.
  - Read: next state WAIT_RD, wait counter cleared to 0.
  - If peripheral_rdata_in_en is already high during the ISSUE cycle of a read: capture the data and go straight to RESP.
- WAIT_RD:
  - Strobes are 0; peripheral_addr_out is held stable.
  - Each cycle: if peripheral_rdata_in_en=1, capture peripheral_rdata_in into rsp_rdata, rsp_err=0, go to RESP.
  - Else if counter==TIMEOUT_CYC-1: rsp_rdata=TIMEOUT_DATA, rsp_err=1, go to RESP.
  - Else increment counter.
  - If data arrives in the same cycle the counter expires, data wins and rsp_err=0.
- RESP:
  - rsp_valid=1, payload held stable until rsp_valid&rsp_ready.
  - On that handshake: rsp_valid=0, go to IDLE; cmd_ready returns to 1 in the next cycle. No overlap between commands.
- Latency from command handshake at edge T:
  - write: rsp_valid at T+2.
  - registered responder read (data_en at T+2): rsp_valid at T+3.
  - timeout: rsp_valid at T+2+TIMEOUT_CYC.
- peripheral_rdata_in_en in IDLE or RESP, or during a write, is ignored. It does not alter the held response.
- rsp_ready held low: block stalls in RESP indefinitely; cmd_ready stays 0.
- No address checking: writes to unmapped addresses complete normally with rsp_err=0.
- Reset mid-operation: the cycle after rst_n_125 is sampled low, any strobe is deasserted and the FSM is in IDLE. An in-flight response is discarded.

Optional Feature:
- Macro: PERIPH_MASTER_ERRCNT_EN.
- Defined: err_cnt increments by 1 on each read timeout (the transition into RESP with rsp_err=1). It saturates at all-ones and clears only on reset.
- Undefined: err_cnt is constant 0 and no counter logic is synthesized. All other behaviour is identical.

Test Plan:
- Write: cmd addr 0x0001_0000, wdata 0x1234_5678, write=1 -> at T+1 one-cycle peripheral_write_en with addr/wdata on bus; rsp_valid at T+2 with rsp_err=0, rsp_rdata=0.
- Read, registered responder: addr 0x0001_1004, responder returns 0x0000_00A5 with data_en at T+2 -> single read_en at T+1; rsp_valid at T+3, rsp_rdata=0x0000_00A5, rsp_err=0.
- Read timeout: addr 0x0002_0000, no data_en -> rsp_valid at T+18 (TIMEOUT_CYC=16), rsp_rdata=0xDEAD_BEEF, rsp_err=1; err_cnt=1 with macro defined, 0 without.
- Race and stray strobe: data_en coincides with the last WAIT_RD cycle -> data returned, rsp_err=0. A stray data_en in IDLE produces no response.
- Backpressure: rsp_ready=0 for 5 cycles after a read completes -> rsp_valid and rsp_rdata stable, cmd_ready=0. The next command is accepted only after the response handshake.
- Reset during WAIT_RD: rst_n_125 low for 1 cycle -> strobes 0, rsp_valid=0, cmd_ready=1 next cycle. A following write completes normally.

Source files
------------

// File: rtl/periph_bus_master.sv
// Peripheral register bus initiator: one command in flight, single-cycle rd/wr strobe, read timeout.
// Latency: write rsp 2 cycles after cmd handshake, read 1 + responder delay, timeout 2 + TIMEOUT_CYC.
// Backpressure: holds response until rsp_ready, cmd_ready low meanwhile; PERIPH_MASTER_ERRCNT_EN adds err_cnt.
module periph_bus_master #(
    parameter int          TIMEOUT_CYC  = 16,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF,
    parameter int          CNT_W        = 8
) (
    input  logic             clk_125,
    input  logic             rst_n_125,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_write,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic [31:0]      peripheral_addr_out,
    output logic [31:0]      peripheral_wdata_out,
    output logic             peripheral_read_en,
    output logic             peripheral_write_en,
    input  logic [31:0]      peripheral_rdata_in,
    input  logic             peripheral_rdata_in_en,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

    typedef struct packed {
        logic        write;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state;
    rsp_t       rsp_q;
    logic [7:0] wait_cnt;
    logic       is_write;
    logic       wait_expired;

    assign wait_expired = (wait_cnt == WAIT_LAST);

    assign rsp_write = rsp_q.write;
    assign rsp_err   = rsp_q.err;
    assign rsp_rdata = rsp_q.rdata;

    always_ff @(posedge clk_125) begin
        if (!rst_n_125) begin
            state                <= IDLE;
            cmd_ready            <= 1'b1;
            rsp_valid            <= 1'b0;
            rsp_q                <= '0;
            peripheral_addr_out  <= '0;
            peripheral_wdata_out <= '0;
            peripheral_read_en   <= 1'b0;
            peripheral_write_en  <= 1'b0;
            wait_cnt             <= '0;
            is_write             <= 1'b0;
        end else begin
            // Strobes are single-cycle: only the IDLE accept path raises them.
            peripheral_read_en  <= 1'b0;
            peripheral_write_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        peripheral_addr_out  <= cmd_addr;
                        peripheral_wdata_out <= cmd_wdata;
                        peripheral_write_en  <= cmd_write;
                        peripheral_read_en   <= !cmd_write;
                        is_write             <= cmd_write;
                        cmd_ready            <= 1'b0;
                        state                <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (is_write) begin
                        rsp_q     <= '{write: 1'b1, err: 1'b0, rdata: 32'h0};
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (peripheral_rdata_in_en) begin
                        rsp_q     <= '{write: 1'b0, err: 1'b0, rdata: peripheral_rdata_in};
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= '0;
                        state    <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    // Arriving data takes priority over an expiring counter.
                    if (peripheral_rdata_in_en) begin
                        rsp_q     <= '{write: 1'b0, err: 1'b0, rdata: peripheral_rdata_in};
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (wait_expired) begin
                        rsp_q     <= '{write: 1'b0, err: 1'b1, rdata: TIMEOUT_DATA};
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PERIPH_MASTER_ERRCNT_EN
    logic timeout_hit;

    assign timeout_hit = (state == WAIT_RD) && !peripheral_rdata_in_en && wait_expired;

    always_ff @(posedge clk_125) begin
        if (!rst_n_125) begin
            err_cnt <= '0;
        end else if (timeout_hit && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_periph_bus_master.sv
// Directed bench for periph_bus_master: stimulus pushes expected responses, a negedge monitor checks them.
module tb_periph_bus_master;

    localparam int CNT_W = 8;
`ifdef PERIPH_MASTER_ERRCNT_EN
    localparam int ERRCNT_ON = 1;
`else
    localparam int ERRCNT_ON = 0;
`endif

    logic             clk_125 = 1'b0;
    logic             rst_n_125;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [31:0]      cmd_addr;
    logic [31:0]      cmd_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_write;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic [31:0]      peripheral_addr_out;
    logic [31:0]      peripheral_wdata_out;
    logic             peripheral_read_en;
    logic             peripheral_write_en;
    logic [31:0]      peripheral_rdata_in;
    logic             peripheral_rdata_in_en;
    logic [CNT_W-1:0] err_cnt;

    periph_bus_master #(
        .TIMEOUT_CYC (16),
        .TIMEOUT_DATA(32'hDEAD_BEEF),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_125               (clk_125),
        .rst_n_125             (rst_n_125),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_write             (cmd_write),
        .cmd_addr              (cmd_addr),
        .cmd_wdata             (cmd_wdata),
        .rsp_valid             (rsp_valid),
        .rsp_ready             (rsp_ready),
        .rsp_write             (rsp_write),
        .rsp_rdata             (rsp_rdata),
        .rsp_err               (rsp_err),
        .peripheral_addr_out   (peripheral_addr_out),
        .peripheral_wdata_out  (peripheral_wdata_out),
        .peripheral_read_en    (peripheral_read_en),
        .peripheral_write_en   (peripheral_write_en),
        .peripheral_rdata_in   (peripheral_rdata_in),
        .peripheral_rdata_in_en(peripheral_rdata_in_en),
        .err_cnt               (err_cnt)
    );

    always #4 clk_125 = ~clk_125;

    int cyc = 0;
    always @(posedge clk_125) cyc <= cyc + 1;

    typedef struct {
        logic        write;
        logic        err;
        logic [31:0] rdata;
        int          seen;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   busy    = 1'b0;
    bit   stray   = 1'b0;
    int   last_hs = 0;
    int   checks  = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_125);
        #1;
    endtask

    // Response monitor: pops one expectation per response, then checks the held payload every cycle.
    initial begin
        forever begin
            @(negedge clk_125);
            if (!rst_n_125) begin
                busy  = 1'b0;
                stray = 1'b0;
            end else if (rsp_valid) begin
                if (!busy) begin
                    busy = 1'b1;
                    if (q.size() == 0) begin
                        stray = 1'b1;
                        checks++;
                        failures++;
                        $display("FAIL unexpected_rsp actual=rsp_valid=1 required=no response (cycle %0d)", cyc);
                    end else begin
                        cur = q.pop_front();
                        chk("rsp_latency", cyc, cur.seen);
                    end
                end
                if (!stray) begin
                    chk("rsp_write", {31'h0, rsp_write}, {31'h0, cur.write});
                    chk("rsp_rdata", rsp_rdata, cur.rdata);
                    chk("rsp_err", {31'h0, rsp_err}, {31'h0, cur.err});
                end
                if (rsp_ready) begin
                    busy    = 1'b0;
                    stray   = 1'b0;
                    last_hs = cyc + 1;
                end
            end
        end
    end

    // d = cycle offset at which the responder drives rdata_in_en (0 = during ISSUE, <0 = never).
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int d, input logic [31:0] rdata, input bit push,
                        input int lat, input logic exp_err, input logic [31:0] exp_rdata,
                        output int t_acc);
        int n;
        tick();
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", {31'h0, cmd_ready}, 32'h1);
            cmd_valid = 1'b0;
            t_acc = -1;
            return;
        end
        t_acc = cyc + 1;
        if (push) q.push_back('{write: wr, err: exp_err, rdata: exp_rdata, seen: t_acc + lat - 1});
        tick();
        cmd_valid = 1'b0;
        chk("issue_write_en", {31'h0, peripheral_write_en}, {31'h0, wr});
        chk("issue_read_en", {31'h0, peripheral_read_en}, {31'h0, !wr});
        chk("issue_addr", peripheral_addr_out, addr);
        chk("issue_wdata", peripheral_wdata_out, wdata);
        chk("issue_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        if (d == 0) begin
            peripheral_rdata_in_en = 1'b1;
            peripheral_rdata_in    = rdata;
        end
        tick();
        peripheral_rdata_in_en = 1'b0;
        chk("strobe_one_cycle", {30'h0, peripheral_write_en, peripheral_read_en}, 32'h0);
        if (d >= 1) begin
            repeat (d - 1) tick();
            peripheral_rdata_in_en = 1'b1;
            peripheral_rdata_in    = rdata;
            tick();
            peripheral_rdata_in_en = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(q.size() == 0 && !busy && !rsp_valid && cmd_ready) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("wait_done_timeout", {31'h0, rsp_valid}, 32'h0);
    endtask

    initial begin
        int t;
        int n;
        rst_n_125              = 1'b0;
        cmd_valid              = 1'b0;
        cmd_write              = 1'b0;
        cmd_addr               = '0;
        cmd_wdata              = '0;
        rsp_ready              = 1'b1;
        peripheral_rdata_in    = '0;
        peripheral_rdata_in_en = 1'b0;
        repeat (3) tick();

        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_payload", {rsp_write, rsp_err, rsp_rdata[29:0]}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_strobes", {30'h0, peripheral_write_en, peripheral_read_en}, 32'h0);
        chk("rst_addr", peripheral_addr_out, 32'h0);
        chk("rst_wdata", peripheral_wdata_out, 32'h0);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        rst_n_125 = 1'b1;
        tick();

        // Plain write
        send(1'b1, 32'h0001_0000, 32'h1234_5678, -1, 32'h0, 1'b1, 2, 1'b0, 32'h0, t);
        wait_done();

        // Registered responder read
        send(1'b0, 32'h0001_1004, 32'h0, 1, 32'h0000_00A5, 1'b1, 3, 1'b0, 32'h0000_00A5, t);
        wait_done();

        // Timeout read; bus address must stay put while waiting
        send(1'b0, 32'h0002_0000, 32'h0, -1, 32'h0, 1'b1, 18, 1'b1, 32'hDEAD_BEEF, t);
        tick();
        chk("wait_addr_hold", peripheral_addr_out, 32'h0002_0000);
        wait_done();
        chk("err_cnt_after_timeout", 32'(err_cnt), ERRCNT_ON);

        // Data coincides with the final wait cycle: data wins
        send(1'b0, 32'h0002_0004, 32'h0, 16, 32'h5A5A_0001, 1'b1, 18, 1'b0, 32'h5A5A_0001, t);
        wait_done();
        chk("err_cnt_after_race", 32'(err_cnt), ERRCNT_ON);

        // Data already present during the ISSUE cycle
        send(1'b0, 32'h0004_0010, 32'h0, 0, 32'h0BAD_F00D, 1'b1, 2, 1'b0, 32'h0BAD_F00D, t);
        wait_done();

        // Write to unmapped block with a stray data strobe: normal completion, rdata 0
        send(1'b1, 32'hFFFF_0010, 32'hA5A5_A5A5, 1, 32'h7777_7777, 1'b1, 2, 1'b0, 32'h0, t);
        wait_done();

        // Stray data strobe while idle
        tick();
        peripheral_rdata_in_en = 1'b1;
        peripheral_rdata_in    = 32'h1111_2222;
        tick();
        peripheral_rdata_in_en = 1'b0;
        repeat (3) tick();
        chk("idle_stray_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("idle_stray_cmd_ready", {31'h0, cmd_ready}, 32'h1);

        // Backpressure: hold response, a pending command must wait for the handshake
        rsp_ready = 1'b0;
        send(1'b0, 32'h0001_2000, 32'h0, 1, 32'hCAFE_0042, 1'b1, 3, 1'b0, 32'hCAFE_0042, t);
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0003_0008;
        cmd_wdata = 32'h0000_0077;
        repeat (5) begin
            tick();
            chk("stall_cmd_ready", {31'h0, cmd_ready}, 32'h0);
            chk("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        end
        rsp_ready = 1'b1;
        send(1'b1, 32'h0003_0008, 32'h0000_0077, -1, 32'h0, 1'b1, 2, 1'b0, 32'h0, t);
        chk("accept_after_handshake", t, last_hs + 1);
        wait_done();

        // Reset while waiting for read data
        send(1'b0, 32'h0005_0000, 32'h0, -1, 32'h0, 1'b0, 0, 1'b0, 32'h0, t);
        repeat (3) tick();
        rst_n_125 = 1'b0;
        tick();
        chk("midrst_strobes", {30'h0, peripheral_write_en, peripheral_read_en}, 32'h0);
        chk("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("midrst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        rst_n_125 = 1'b1;
        send(1'b1, 32'h0006_0004, 32'h0BEE_F00D, -1, 32'h0, 1'b1, 2, 1'b0, 32'h0, t);
        wait_done();
        repeat (20) tick();
        chk("post_rst_quiet", {31'h0, rsp_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
